multiply_add_unit: RTL and testbench

- Radix-2 FFT butterfly datapath.
- Takes complex operands A and B and a twiddle factor w. Produces Y = A + w·B and Z = A − w·B.
- Every complex value is packed in 32 bits as {real[31:16], imag[15:0]}.
- Each component is signed fixed point with 10 fraction bits: 1.0 = 0x0400.
- Sits between the FFT stage input registers and the stage output buffer.
- Fully pipelined: accepts one butterfly per clock.

---
 rtl/multiply_add_unit.sv | 149 ++++++++++++++
 tb/tb_multiply_add_unit.sv | 135 +++++++++++++
 2 files changed

// File: rtl/multiply_add_unit.sv
// Radix-2 FFT butterfly: Y = A + w*B, Z = A - w*B on packed {real, imag} Q6.10 operands.
// Three register stages (operands, products, saturated results), one butterfly per clock.
module multiply_add_unit #(
  parameter int DW   = 16,
  parameter int FRAC = 10
) (
  input  logic            Clk,
  input  logic            Rst,
  input  logic [2*DW-1:0] A,
  input  logic [2*DW-1:0] B,
  input  logic [2*DW-1:0] w,
  output logic [2*DW-1:0] Y,
  output logic [2*DW-1:0] Z
);

  localparam int PW = 2 * DW;      // one signed product
  localparam int SW = 2 * DW + 2;  // butterfly sum before saturation

  // Arithmetic shift by FRAC: truncation toward minus infinity, width kept.
  function automatic logic signed [PW:0] scale(input logic signed [PW:0] p);
    return p >>> FRAC;
  endfunction

  // Clip a wide signed sum to DW bits; in range when all bits above DW-2 agree.
  function automatic logic signed [DW-1:0] sat(input logic signed [SW-1:0] x);
    logic [SW-DW:0] top;
    top = x[SW-1:DW-1];
    if (top == '0 || top == '1)
      return x[DW-1:0];
    else if (x[SW-1])
      return {1'b1, {(DW-1){1'b0}}};
    else
      return {1'b0, {(DW-1){1'b1}}};
  endfunction

  // Stage 1: operand registers
  logic [2*DW-1:0] a_p0;
  logic [2*DW-1:0] b_p0;
  logic [2*DW-1:0] w_p0;
  logic            vld_p0;

  always_ff @(posedge Clk) begin
    if (Rst) begin
      a_p0   <= '0;
      b_p0   <= '0;
      w_p0   <= '0;
      vld_p0 <= 1'b0;
    end else begin
      a_p0   <= A;
      b_p0   <= B;
      w_p0   <= w;
      vld_p0 <= 1'b1;
    end
  end

  logic signed [DW-1:0] br_p0;
  logic signed [DW-1:0] bi_p0;
  logic signed [DW-1:0] wr_p0;
  logic signed [DW-1:0] wi_p0;
  logic signed [PW-1:0] brwr_p0;
  logic signed [PW-1:0] biwi_p0;
  logic signed [PW-1:0] biwr_p0;
  logic signed [PW-1:0] brwi_p0;

  always_comb begin
    br_p0   = b_p0[2*DW-1:DW];
    bi_p0   = b_p0[DW-1:0];
    wr_p0   = w_p0[2*DW-1:DW];
    wi_p0   = w_p0[DW-1:0];
    brwr_p0 = br_p0 * wr_p0;
    biwi_p0 = bi_p0 * wi_p0;
    biwr_p0 = bi_p0 * wr_p0;
    brwi_p0 = br_p0 * wi_p0;
  end

  // Stage 2: product registers, A delayed alongside
  logic signed [DW-1:0] ar_p1;
  logic signed [DW-1:0] ai_p1;
  logic signed [PW-1:0] brwr_p1;
  logic signed [PW-1:0] biwi_p1;
  logic signed [PW-1:0] biwr_p1;
  logic signed [PW-1:0] brwi_p1;
  logic                 vld_p1;

  always_ff @(posedge Clk) begin
    if (Rst) begin
      ar_p1   <= '0;
      ai_p1   <= '0;
      brwr_p1 <= '0;
      biwi_p1 <= '0;
      biwr_p1 <= '0;
      brwi_p1 <= '0;
      vld_p1  <= 1'b0;
    end else begin
      ar_p1   <= a_p0[2*DW-1:DW];
      ai_p1   <= a_p0[DW-1:0];
      brwr_p1 <= brwr_p0;
      biwi_p1 <= biwi_p0;
      biwr_p1 <= biwr_p0;
      brwi_p1 <= brwi_p0;
      vld_p1  <= vld_p0;
    end
  end

  logic signed [PW:0]    pr_p1;
  logic signed [PW:0]    pi_p1;
  logic signed [PW:0]    prs_p1;
  logic signed [PW:0]    pis_p1;
  logic signed [SW-1:0]  are_p1;
  logic signed [SW-1:0]  aie_p1;
  logic signed [SW-1:0]  yr_p1;
  logic signed [SW-1:0]  yi_p1;
  logic signed [SW-1:0]  zr_p1;
  logic signed [SW-1:0]  zi_p1;

  always_comb begin
    pr_p1  = $signed({brwr_p1[PW-1], brwr_p1}) - $signed({biwi_p1[PW-1], biwi_p1});
    pi_p1  = $signed({biwr_p1[PW-1], biwr_p1}) + $signed({brwi_p1[PW-1], brwi_p1});
    prs_p1 = scale(pr_p1);
    pis_p1 = scale(pi_p1);
    are_p1 = $signed({{(SW-DW){ar_p1[DW-1]}}, ar_p1});
    aie_p1 = $signed({{(SW-DW){ai_p1[DW-1]}}, ai_p1});
    yr_p1  = are_p1 + $signed({prs_p1[PW], prs_p1});
    yi_p1  = aie_p1 + $signed({pis_p1[PW], pis_p1});
    zr_p1  = are_p1 - $signed({prs_p1[PW], prs_p1});
    zi_p1  = aie_p1 - $signed({pis_p1[PW], pis_p1});
  end

  // Stage 3: saturated, repacked results
  logic [2*DW-1:0] y_p2;
  logic [2*DW-1:0] z_p2;

  always_ff @(posedge Clk) begin
    if (Rst) begin
      y_p2 <= '0;
      z_p2 <= '0;
    end else if (vld_p1) begin
      y_p2 <= {sat(yr_p1), sat(yi_p1)};
      z_p2 <= {sat(zr_p1), sat(zi_p1)};
    end else begin
      y_p2 <= '0;
      z_p2 <= '0;
    end
  end

  assign Y = y_p2;
  assign Z = z_p2;

endmodule

// File: tb/tb_multiply_add_unit.sv
// Directed and model-driven scoreboard bench for the FFT butterfly pipeline.
module tb_multiply_add_unit;

  logic        Clk = 1'b0;
  logic        Rst;
  logic [31:0] A;
  logic [31:0] B;
  logic [31:0] w;
  logic [31:0] Y;
  logic [31:0] Z;

  int n_checks = 0;
  int n_fails  = 0;

  typedef struct {
    logic [31:0] y;
    logic [31:0] z;
    string       tag;
  } exp_t;

  exp_t sb[$];

  multiply_add_unit #(.DW(16), .FRAC(10)) dut (
    .Clk(Clk), .Rst(Rst), .A(A), .B(B), .w(w), .Y(Y), .Z(Z)
  );

  always #5 Clk = ~Clk;

  // Floor division by 2^10 written without shifts.
  function automatic longint floor_div(input longint p);
    if (p >= 0) return p / 1024;
    return -((-p + 1023) / 1024);
  endfunction

  function automatic logic [15:0] clip16(input longint v);
    longint t;
    if (v > 32767) return 16'h7FFF;
    if (v < -32768) return 16'h8000;
    t = v;
    return t[15:0];
  endfunction

  function automatic void model(input logic [31:0] a, input logic [31:0] b, input logic [31:0] ww,
                                output logic [31:0] y, output logic [31:0] z);
    longint ar, ai, br, bi, wr, wi, pr, pi;
    ar = longint'($signed(a[31:16]));
    ai = longint'($signed(a[15:0]));
    br = longint'($signed(b[31:16]));
    bi = longint'($signed(b[15:0]));
    wr = longint'($signed(ww[31:16]));
    wi = longint'($signed(ww[15:0]));
    pr = floor_div(br * wr - bi * wi);
    pi = floor_div(bi * wr + br * wi);
    y  = {clip16(ar + pr), clip16(ai + pi)};
    z  = {clip16(ar - pr), clip16(ai - pi)};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fails++;
      $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
    end
  endtask

  // One clock: drive inputs, push expectation, compare the result leaving stage 3.
  task automatic step(input logic rst, input logic [31:0] a, input logic [31:0] b,
                      input logic [31:0] ww, input logic [31:0] ey, input logic [31:0] ez,
                      input string tag);
    exp_t e;
    Rst = rst;
    A   = a;
    B   = b;
    w   = ww;
    if (!rst) sb.push_back(exp_t'{ey, ez, tag});
    @(posedge Clk);
    #1;
    if (rst) begin
      sb.delete();
      check({tag, "_y"}, Y, 32'h0);
      check({tag, "_z"}, Z, 32'h0);
      sb.push_back(exp_t'{32'h0, 32'h0, "flush_s2"});
      sb.push_back(exp_t'{32'h0, 32'h0, "flush_s1"});
    end else if (sb.size() == 3) begin
      e = sb.pop_front();
      check({e.tag, "_y"}, Y, e.y);
      check({e.tag, "_z"}, Z, e.z);
    end
  endtask

  task automatic step_m(input logic [31:0] a, input logic [31:0] b, input logic [31:0] ww,
                        input string tag);
    logic [31:0] ey, ez;
    model(a, b, ww, ey, ez);
    step(1'b0, a, b, ww, ey, ez, tag);
  endtask

  initial begin
    Rst = 1'b1;
    A   = 32'h0;
    B   = 32'h0;
    w   = 32'h0;

    step(1'b1, 32'h12345678, 32'h0BADF00D, 32'h04000400, 32'h0, 32'h0, "rst0");
    step(1'b1, 32'h7FFF8000, 32'h80007FFF, 32'hFFFF0001, 32'h0, 32'h0, "rst1");

    // Back-to-back directed cases, including the first outputs after release
    step(1'b0, 32'h04000000, 32'h02000100, 32'h04000000, 32'h06000100, 32'h0200FF00, "unity");
    step(1'b0, 32'h013600B3, 32'h02A60800, 32'hFFFF00EB, 32'hFF5F014C, 32'h030D001A, "trunc");
    step(1'b0, 32'h7FFF0000, 32'h04000000, 32'h04000000, 32'h7FFF0000, 32'h7BFF0000, "sat_hi");
    step(1'b0, 32'h80000000, 32'h04000000, 32'h04000000, 32'h84000000, 32'h80000000, "sat_lo");

    step_m(32'h00000000, 32'h80008000, 32'h80008000, "min_ops");
    step_m(32'h80008000, 32'h7FFF7FFF, 32'h7FFF8000, "mixed_ext");
    step_m(32'h00010001, 32'hFFFFFFFF, 32'h00010001, "tiny_neg");
    step_m(32'h7FFF7FFF, 32'h7FFF7FFF, 32'h7FFF7FFF, "max_ops");
    for (int i = 0; i < 16; i++) begin
      step_m($urandom, $urandom, $urandom, $sformatf("rand%0d", i));
    end

    // Reset while "trunc" sits in stage 2; its result must never surface
    step(1'b0, 32'h013600B3, 32'h02A60800, 32'hFFFF00EB, 32'hFF5F014C, 32'h030D001A, "trunc_lost");
    step(1'b0, 32'h04000000, 32'h02000100, 32'h04000000, 32'h06000100, 32'h0200FF00, "unity_lost");
    step(1'b1, 32'h7FFF0000, 32'h04000000, 32'h04000000, 32'h0, 32'h0, "rst_mid");
    step(1'b0, 32'h04000000, 32'h02000100, 32'h04000000, 32'h06000100, 32'h0200FF00, "unity2");
    step(1'b0, 32'h7FFF0000, 32'h04000000, 32'h04000000, 32'h7FFF0000, 32'h7BFF0000, "sat_hi2");
    step_m(32'h00000000, 32'h00000000, 32'h00000000, "drain0");
    step_m(32'h00000000, 32'h00000000, 32'h00000000, "drain1");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
